// File: rtl/nes_pkg.sv
// Shared NES system definitions: CPU-visible register addresses and the
// sprite DMA state encoding.
package nes_pkg;

    localparam logic [15:0] APU_OAMDMA  = 16'h4014;
    localparam logic [15:0] PPU_OAMDATA = 16'h2004;

    typedef enum logic [2:0] {IDLE, REQ, HALT, ALIGN, READ, WRITE} dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to the trigger register copies one page of CPU memory
// into PPU OAMDATA through alternating read/write cycles on the shared bus.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = APU_OAMDMA,
    parameter logic [15:0] DEST_ADDR = PPU_OAMDATA,
    parameter int unsigned LEN       = 256
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] snoop_addr,
    input  logic [7:0]  snoop_data,
    input  logic        snoop_we,
    input  logic [7:0]  rd_data,
    output logic        req,
    input  logic        grant,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_rw,
    output logic        dma_oe,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    dma_state_t state, state_next;
    logic [7:0] page;
    logic [7:0] idx;
    logic       parity;
    logic       trigger;
    logic       on_bus;
    logic       last_write;

    assign trigger    = (state == IDLE) && snoop_we && (snoop_addr == TRIG_ADDR);
    assign on_bus     = grant && ((state == READ) || (state == WRITE));
    assign last_write = grant && (state == WRITE) && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every state past REQ freezes while the arbiter withholds the bus.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        busy       = 1'b0;
        dma_oe     = 1'b0;
        dma_rw     = 1'b1;
        dma_addr   = '0;

        case (state)
            IDLE:  if (trigger) state_next = REQ;
            REQ:   if (grant) state_next = HALT;
            HALT:  if (grant) state_next = parity ? ALIGN : READ;
            ALIGN: if (grant) state_next = READ;
            READ:  if (grant) state_next = WRITE;
            WRITE: if (grant) state_next = (idx == LAST_IDX) ? IDLE : READ;
            default: state_next = IDLE;
        endcase

        if (state != IDLE) begin
            req  = 1'b1;
            busy = 1'b1;
        end

        if (on_bus) begin
            dma_oe = 1'b1;
            if (state == READ) begin
                dma_addr = {page, idx};
            end else begin
                dma_rw   = 1'b0;
                dma_addr = DEST_ADDR;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            page      <= '0;
            idx       <= '0;
            dma_wdata <= '0;
            parity    <= 1'b0;
            done      <= 1'b0;
        end else begin
            parity <= ~parity;
            done   <= last_write;
            if (trigger) begin
                page <= snoop_data;
                idx  <= '0;
            end
            if (grant && (state == READ)) begin
                dma_wdata <= rd_data;
            end
            if (grant && (state == WRITE) && (idx != LAST_IDX)) begin
                idx <= idx + 8'd1;
            end
        end
    end

endmodule
